// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC and the fetch FSM, applies
// LUT-supplied relative branch offsets and detects out-of-range targets.
module pc_sequencer #(
   parameter int D        = 12,
   parameter int PROG_LEN = 1024,
   parameter int START_PC = 0,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stall,
   input  logic          branch_req,
   input  logic [1:0]    branch_sel,
   input  logic          halt_req,
   output logic [1:0]    lut_addr,
   input  logic [D-1:0]  lut_target,
   output logic [D-1:0]  prog_ctr,
   output logic          fetch_valid,
   output logic          flush,
   output logic          done,
   output logic          fault,
   output logic [CW-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DONE,
      S_FAULT
   } state_e;

   localparam logic [D:0]   LEN   = (D+1)'(PROG_LEN);
   localparam logic [D-1:0] START = D'(START_PC);

   state_e        state_q, state_d;
   logic [D-1:0]  pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fetch_valid_q, fetch_valid_d;
   logic          flush_q, flush_d;
   logic          done_q, done_d;
   logic          fault_q, fault_d;

   logic [D-1:0]  br_sum;
   logic [D:0]    seq_sum;
   logic [CW-1:0] cnt_inc;

   assign lut_addr = branch_sel;

   // Branch target wraps at D bits; sequential next keeps the carry so
   // running off a full 2**D program is still caught.
   always_comb begin
      br_sum  = pc_q + lut_target;
      seq_sum = {1'b0, pc_q} + (D+1)'(1);
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               pc_d    = START;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!stall) begin
               cnt_d = cnt_inc;
               if (halt_req) begin
                  state_d = S_DONE;
               end else if (branch_req) begin
                  if ({1'b0, br_sum} < LEN) begin
                     pc_d    = br_sum;
                     state_d = S_FLUSH;
                  end else begin
                     state_d = S_FAULT;
                  end
               end else if (seq_sum >= LEN) begin
                  state_d = S_FAULT;
               end else begin
                  pc_d = seq_sum[D-1:0];
               end
            end
         end
         S_FLUSH: state_d = S_RUN;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fetch_valid_d = (state_d == S_RUN);
      flush_d       = (state_d == S_FLUSH);
      done_d        = (state_d == S_DONE);
      fault_d       = (state_d == S_FAULT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         cnt_q         <= '0;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
         done_q        <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         cnt_q         <= cnt_d;
         fetch_valid_q <= fetch_valid_d;
         flush_q       <= flush_d;
         done_q        <= done_d;
         fault_q       <= fault_d;
      end
   end

   assign prog_ctr    = pc_q;
   assign instr_cnt   = cnt_q;
   assign fetch_valid = fetch_valid_q;
   assign flush       = flush_q;
   assign done        = done_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_pc_sequencer;

   localparam int D  = 12;
   localparam int PL = 64;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start, stall, branch_req, halt_req;
   logic [1:0]    branch_sel;
   logic [1:0]    lut_addr;
   logic [D-1:0]  lut_target;
   logic [D-1:0]  prog_ctr;
   logic          fetch_valid, flush, done, fault;
   logic [CW-1:0] instr_cnt;

   int nvec = 0;
   int nbad = 0;

   pc_sequencer #(.D(D), .PROG_LEN(PL), .START_PC(0), .CW(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .branch_req(branch_req), .branch_sel(branch_sel),
      .halt_req(halt_req), .lut_addr(lut_addr),
      .lut_target(lut_target), .prog_ctr(prog_ctr),
      .fetch_valid(fetch_valid), .flush(flush), .done(done),
      .fault(fault), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   // LUT stub: -5, +20, -1, 0
   always_comb begin
      lut_target = '0;
      case (lut_addr)
         2'd0: lut_target = 12'hFFB;
         2'd1: lut_target = 12'd20;
         2'd2: lut_target = 12'hFFF;
         default: lut_target = 12'd0;
      endcase
   end

   typedef struct {
      logic st, sl, br;
      logic [1:0] sel;
      logic hl;
      int pc;
      logic fv, fl, dn, ft;
      int cnt;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input int pc, input int fv,
                            input int fl, input int dn, input int ft,
                            input int cnt);
      chk({tag, ".pc"}, int'(prog_ctr), pc);
      chk({tag, ".fv"}, int'(fetch_valid), fv);
      chk({tag, ".flush"}, int'(flush), fl);
      chk({tag, ".done"}, int'(done), dn);
      chk({tag, ".fault"}, int'(fault), ft);
      chk({tag, ".cnt"}, int'(instr_cnt), cnt);
   endtask

   // Inputs change 1 after the edge; lut_addr checked before next edge.
   task automatic step(input logic s, input logic sl, input logic br,
                       input logic [1:0] sel, input logic h);
      start = s; stall = sl; branch_req = br; branch_sel = sel;
      halt_req = h;
      #1;
      chk("lut_addr", int'(lut_addr), int'(sel));
      @(posedge clk);
      #1;
      start = 0; stall = 0; branch_req = 0; halt_req = 0;
   endtask

   task automatic idle_step();
      step(0, 0, 0, 2'd0, 0);
   endtask

   task automatic do_reset();
      reset = 1;
      #1;
      check_out("rst", 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   // Behavioural model
   localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_DONE = 3,
                  M_FAULT = 4;
   int m_st, m_pc, m_cnt;
   int offs[4] = '{-5, 20, -1, 0};

   task automatic model_step(input logic s, input logic sl,
                             input logic br, input int sel,
                             input logic h);
      int tgt;
      case (m_st)
         M_IDLE, M_DONE: if (s) begin
            m_pc = 0; m_cnt = 0; m_st = M_RUN;
         end
         M_RUN: if (!sl) begin
            if (m_cnt < 65535) m_cnt++;
            if (h) m_st = M_DONE;
            else if (br) begin
               tgt = ((m_pc + offs[sel]) % 4096 + 4096) % 4096;
               if (tgt < PL) begin
                  m_pc = tgt; m_st = M_FLUSH;
               end else m_st = M_FAULT;
            end else if (m_pc + 1 >= PL) m_st = M_FAULT;
            else m_pc = m_pc + 1;
         end
         M_FLUSH: m_st = M_RUN;
         default: ;
      endcase
   endtask

   vec_t tbl[17];

   initial begin
      reset = 1; start = 0; stall = 0; branch_req = 0;
      branch_sel = 0; halt_req = 0;

      //             st sl br sel hl  pc fv fl dn ft cnt
      tbl[0]  = '{1, 0, 0, 2'd0, 0,  0, 1, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 2'd0, 0,  1, 1, 0, 0, 0, 1};
      tbl[2]  = '{0, 0, 0, 2'd0, 0,  2, 1, 0, 0, 0, 2};
      tbl[3]  = '{0, 0, 0, 2'd0, 0,  3, 1, 0, 0, 0, 3};
      tbl[4]  = '{0, 0, 0, 2'd0, 0,  4, 1, 0, 0, 0, 4};
      tbl[5]  = '{0, 0, 1, 2'd1, 0, 24, 0, 1, 0, 0, 5};
      tbl[6]  = '{0, 1, 1, 2'd0, 1, 24, 1, 0, 0, 0, 5};
      tbl[7]  = '{0, 0, 1, 2'd3, 0, 24, 0, 1, 0, 0, 6};
      tbl[8]  = '{1, 0, 0, 2'd0, 0, 24, 1, 0, 0, 0, 6};
      tbl[9]  = '{0, 0, 1, 2'd2, 0, 23, 0, 1, 0, 0, 7};
      tbl[10] = '{0, 0, 0, 2'd0, 0, 23, 1, 0, 0, 0, 7};
      tbl[11] = '{1, 0, 0, 2'd0, 0, 24, 1, 0, 0, 0, 8};
      tbl[12] = '{0, 1, 1, 2'd1, 0, 24, 1, 0, 0, 0, 8};
      tbl[13] = '{0, 1, 0, 2'd0, 1, 24, 1, 0, 0, 0, 8};
      tbl[14] = '{0, 0, 1, 2'd1, 1, 24, 0, 0, 1, 0, 9};
      tbl[15] = '{0, 0, 0, 2'd0, 0, 24, 0, 0, 1, 0, 9};
      tbl[16] = '{1, 0, 0, 2'd0, 0,  0, 1, 0, 0, 0, 0};

      #2;
      check_out("por", 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      reset = 0;

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].st, tbl[i].sl, tbl[i].br, tbl[i].sel, tbl[i].hl);
         check_out($sformatf("vec%0d", i), tbl[i].pc, int'(tbl[i].fv),
                   int'(tbl[i].fl), int'(tbl[i].dn), int'(tbl[i].ft),
                   tbl[i].cnt);
      end

      // Branch target wraps out of range -> sticky fault
      do_reset();
      step(1, 0, 0, 2'd0, 0);
      for (int i = 0; i < 3; i++) idle_step();
      check_out("pre_bf", 3, 1, 0, 0, 0, 3);
      step(0, 0, 1, 2'd0, 0);
      check_out("bfault", 3, 0, 0, 0, 1, 4);
      step(1, 0, 0, 2'd0, 0);
      check_out("bf_start", 3, 0, 0, 0, 1, 4);
      do_reset();
      check_out("bf_clr", 0, 0, 0, 0, 0, 0);

      // Run off the end of the program
      step(1, 0, 0, 2'd0, 0);
      for (int i = 0; i < 63; i++) idle_step();
      check_out("at63", 63, 1, 0, 0, 0, 63);
      idle_step();
      check_out("end_fault", 63, 0, 0, 0, 1, 64);

      // Stall holds, then halt beats branch, then restart
      do_reset();
      step(1, 0, 0, 2'd0, 0);
      for (int i = 0; i < 10; i++) idle_step();
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 2'd1, 0);
         check_out($sformatf("stall%0d", i), 10, 1, 0, 0, 0, 10);
      end
      step(0, 0, 1, 2'd1, 1);
      check_out("halt", 10, 0, 0, 1, 0, 11);
      step(1, 0, 0, 2'd0, 0);
      check_out("restart", 0, 1, 0, 0, 0, 0);

      // Async reset in FLUSH, no clock edge involved
      for (int i = 0; i < 4; i++) idle_step();
      step(0, 0, 1, 2'd1, 0);
      check_out("in_flush", 24, 0, 1, 0, 0, 5);
      #2;
      reset = 1;
      #1;
      check_out("async_rst", 0, 0, 0, 0, 0, 0);
      reset = 0;
      @(posedge clk);
      #1;
      check_out("post_rst", 0, 0, 0, 0, 0, 0);

      // Randomized traffic against the model
      m_st = M_IDLE; m_pc = 0; m_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
         logic s, sl, br, h;
         logic [1:0] sel;
         if ((m_st == M_FAULT && $urandom_range(3) == 0) ||
             $urandom_range(299) == 0) begin
            do_reset();
            m_st = M_IDLE; m_pc = 0; m_cnt = 0;
         end else begin
            s   = ($urandom_range(7) == 0);
            sl  = ($urandom_range(3) == 0);
            br  = ($urandom_range(7) == 0);
            h   = ($urandom_range(39) == 0);
            sel = 2'($urandom_range(3));
            step(s, sl, br, sel, h);
            model_step(s, sl, br, int'(sel), h);
            check_out($sformatf("rnd%0d", n), m_pc,
                      int'(m_st == M_RUN), int'(m_st == M_FLUSH),
                      int'(m_st == M_DONE), int'(m_st == M_FAULT),
                      m_cnt);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the single-issue teaching processor.
- Owns the PC register and the fetch FSM.
- Drives the address input of the branch-target LUT (4 entries, D-bit two's-complement relative offsets) and applies the returned offset on taken branches.
- Handles stall, one-bubble flush after a taken branch, halt, and out-of-range branch detection. Sits between instruction decode and instruction ROM.

Parameters:
- D, 12, PC / offset width in bits
- PROG_LEN, 1024, number of valid instruction addresses; legal PC range is 0..PROG_LEN-1; must be <= 2**D
- START_PC, 0, PC loaded on start
- CW, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin execution from START_PC; honoured only in IDLE or DONE
- stall  in  1  freeze PC and FSM for this cycle
- branch_req  in  1  decoded taken relative branch for the current instruction
- branch_sel  in  2  which LUT entry supplies the offset
- halt_req  in  1  current instruction is HALT
- lut_addr  out  2  to LUT address; equals branch_sel combinationally
- lut_target  in  D  offset from LUT; combinational, same cycle
- prog_ctr  out  D  current PC, to instruction ROM
- fetch_valid  out  1  prog_ctr addresses a live instruction this cycle
- flush  out  1  squash the instruction fetched behind a taken branch
- done  out  1  program halted normally
- fault  out  1  branch target out of range; sticky
- instr_cnt  out  CW  retired instruction count

Behaviour:
- States: IDLE, RUN, FLUSH, DONE, FAULT.
- Reset (async, any time, including mid-branch or mid-stall): state=IDLE, prog_ctr=0, instr_cnt=0. All 1-bit outputs are 0.
- Outputs are Moore from state, except lut_addr (pure combinational pass-through):
  - fetch_valid = (state==RUN)
  - flush = (state==FLUSH)
  - done = (state==DONE)
  - fault = (state==FAULT)
- IDLE: on start, prog_ctr<=START_PC and instr_cnt<=0, then go to RUN. Otherwise hold.
- RUN, stall=1: prog_ctr, instr_cnt and state all hold. branch_req and halt_req are ignored that cycle; decode must re-present them.
- RUN, stall=0: the instruction retires and instr_cnt increments, saturating at all-ones. Priority is halt > branch > sequential.
  - halt_req=1: go to DONE; prog_ctr holds (points at HALT).
  - branch_req=1: compute nxt = (prog_ctr + lut_target) mod 2**D (D-bit wrap, unsigned sum).
    - If nxt < PROG_LEN: prog_ctr<=nxt, go to FLUSH.
    - Else: go to FAULT; prog_ctr holds at the branch address.
  - otherwise: nxt = prog_ctr+1.
    - If nxt >= PROG_LEN (ran off end): go to FAULT, prog_ctr holds.
    - Else: prog_ctr<=nxt, stay in RUN.
- Zero offset is legal: branch to self, still takes a FLUSH bubble.
- FLUSH: exactly one cycle, unconditional (stall ignored), then RUN. prog_ctr holds the branch target. Latency from branch retire to the target being fetch_valid is 2 cycles.
- DONE: hold. start restarts exactly as from IDLE.
- FAULT: sticky; start is ignored; only reset exits.
- start while in RUN or FLUSH is ignored.

Test Plan:
- Setup: PROG_LEN=64, START_PC=0; LUT stub returns -5, +20, -1, 0 for addresses 0..3.
- Reset, then pulse start, no stall -> prog_ctr 0,1,2,3,4 on consecutive RUN cycles, fetch_valid=1 throughout; instr_cnt=4 when prog_ctr=4.
- At prog_ctr=4, branch_req=1, branch_sel=1 -> lut_addr=1 same cycle; next cycle flush=1, fetch_valid=0, prog_ctr=24; following cycle fetch_valid=1 at 24. Repeat at 24 with sel=2 -> 23; with sel=3 -> stays 24 with one flush bubble.
- At prog_ctr=3, branch_sel=0 -> nxt wraps to 4094 >= 64 -> fault=1 next cycle, prog_ctr=3. Asserting start is ignored; only reset clears to IDLE, prog_ctr=0.
- Sequential run to prog_ctr=63 with no halt -> FAULT, prog_ctr=63.
- At prog_ctr=10: stall=1 with branch_req=1 for 3 cycles -> prog_ctr=10 and instr_cnt unchanged. Then stall=0 with halt_req=1 and branch_req=1 together -> done=1, prog_ctr=10. Pulse start -> prog_ctr=0, instr_cnt=0, RUN.
- Assert reset asynchronously mid-cycle while in FLUSH at prog_ctr=24 -> outputs go to reset values immediately, without waiting for a clock edge; state is IDLE after release.
